// File: rtl/ssm_input_loader.sv
// Streams one fp16 frame into the SSM core's flat operand buses, section by section,
// then pulses start_out and holds the buses until the core reports done.
module ssm_input_loader #(
    parameter int B  = 1,
    parameter int H  = 24,
    parameter int P  = 64,
    parameter int N  = 128,
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_last,
    output logic [B*H*DW-1:0]       dt_flat_out,
    output logic [B*H*DW-1:0]       dA_flat_out,
    output logic [B*N*DW-1:0]       Bmat_flat_out,
    output logic [B*N*DW-1:0]       C_flat_out,
    output logic [H*DW-1:0]         D_flat_out,
    output logic [B*H*P*DW-1:0]     x_flat_out,
    output logic [B*H*P*N*DW-1:0]   h_prev_flat_out,
    output logic                    start_out,
    input  logic                    core_done_in,
    output logic                    busy,
    output logic                    frame_err,
    output logic [15:0]             frame_cnt,
    output logic [3:0]              fsm_state
);

    localparam int HLEN = B * H * P * N;
    localparam int CW   = (HLEN > 1) ? $clog2(HLEN) : 1;

    typedef enum logic [3:0] {
        LD_DT, LD_DA, LD_B, LD_C, LD_D, LD_X, LD_H, FIRE, WAIT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, sec_last;
    logic            err_n, cnt_inc, beat, at_last, final_h;

    // Handshake: a beat moves only when in_valid and in_ready are both high at a rising clk.
    assign in_ready  = ~rst & (state != FIRE) & (state != WAIT);
    assign busy      = (state == FIRE) | (state == WAIT);
    assign beat      = in_valid & in_ready;
    assign fsm_state = state;

    always_comb begin
        sec_last = '0;
        unique case (state)
            LD_DT:   sec_last = CW'(B*H - 1);
            LD_DA:   sec_last = CW'(B*H - 1);
            LD_B:    sec_last = CW'(B*N - 1);
            LD_C:    sec_last = CW'(B*N - 1);
            LD_D:    sec_last = CW'(H - 1);
            LD_X:    sec_last = CW'(B*H*P - 1);
            LD_H:    sec_last = CW'(HLEN - 1);
            default: sec_last = '0;
        endcase
    end

    assign at_last = (cnt == sec_last);
    assign final_h = (state == LD_H) & at_last;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = frame_err;
        cnt_inc = 1'b0;
        unique case (state)
            LD_DT, LD_DA, LD_B, LD_C, LD_D, LD_X, LD_H: begin
                if (beat) begin
                    // in_last must coincide exactly with the final LD_H word, else drop the frame.
                    if (in_last != final_h) begin
                        state_n = LD_DT;
                        cnt_n   = '0;
                        err_n   = 1'b1;
                    end else if (at_last) begin
                        state_n = state_t'(state + 4'd1);
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            FIRE: state_n = WAIT;
            WAIT: begin
                if (core_done_in) begin
                    state_n = LD_DT;
                    cnt_n   = '0;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_n = LD_DT;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_DT;
            cnt       <= '0;
            start_out <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            start_out <= (state_n == FIRE);
            frame_err <= err_n;
            if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Buses are never cleared between frames; each accepted word overwrites its own slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            dt_flat_out     <= '0;
            dA_flat_out     <= '0;
            Bmat_flat_out   <= '0;
            C_flat_out      <= '0;
            D_flat_out      <= '0;
            x_flat_out      <= '0;
            h_prev_flat_out <= '0;
        end else if (beat) begin
            unique case (state)
                LD_DT:   dt_flat_out[DW*int'(cnt) +: DW]     <= in_data;
                LD_DA:   dA_flat_out[DW*int'(cnt) +: DW]     <= in_data;
                LD_B:    Bmat_flat_out[DW*int'(cnt) +: DW]   <= in_data;
                LD_C:    C_flat_out[DW*int'(cnt) +: DW]      <= in_data;
                LD_D:    D_flat_out[DW*int'(cnt) +: DW]      <= in_data;
                LD_X:    x_flat_out[DW*int'(cnt) +: DW]      <= in_data;
                LD_H:    h_prev_flat_out[DW*int'(cnt) +: DW] <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssm_input_loader.sv
// Directed and randomized frames against a word-array model of the loader's buses.
module tb_ssm_input_loader;

    localparam int B = 1, H = 2, P = 2, N = 4, DW = 16;
    localparam int FRAME = 34;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DW-1:0]         in_data = '0;
    logic                  in_last = 1'b0;
    logic [B*H*DW-1:0]     dt_flat_out, dA_flat_out;
    logic [B*N*DW-1:0]     Bmat_flat_out, C_flat_out;
    logic [H*DW-1:0]       D_flat_out;
    logic [B*H*P*DW-1:0]   x_flat_out;
    logic [B*H*P*N*DW-1:0] h_prev_flat_out;
    logic                  start_out;
    logic                  core_done_in = 1'b0;
    logic                  busy, frame_err;
    logic [15:0]           frame_cnt;
    logic [3:0]            fsm_state;

    ssm_input_loader #(.B(B), .H(H), .P(P), .N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .dt_flat_out(dt_flat_out), .dA_flat_out(dA_flat_out),
        .Bmat_flat_out(Bmat_flat_out), .C_flat_out(C_flat_out),
        .D_flat_out(D_flat_out), .x_flat_out(x_flat_out),
        .h_prev_flat_out(h_prev_flat_out), .start_out(start_out),
        .core_done_in(core_done_in), .busy(busy), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the frame is one flat list of words; sections are slices of it.
    logic [DW-1:0] exp_words [FRAME];
    logic          exp_err = 1'b0;
    logic [15:0]   exp_cnt = '0;
    int            sec_off [7] = '{0, 2, 4, 8, 12, 14, 18};
    int            sec_len [7] = '{2, 2, 4, 4, 2, 4, 16};

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_buses(input string tag);
        logic [255:0] e, o;
        for (int s = 0; s < 7; s++) begin
            e = '0;
            for (int k = 0; k < sec_len[s]; k++) e[16*k +: 16] = exp_words[sec_off[s] + k];
            case (s)
                0: o = 256'(dt_flat_out);
                1: o = 256'(dA_flat_out);
                2: o = 256'(Bmat_flat_out);
                3: o = 256'(C_flat_out);
                4: o = 256'(D_flat_out);
                5: o = 256'(x_flat_out);
                default: o = 256'(h_prev_flat_out);
            endcase
            chk($sformatf("%s_bus%0d", tag, s), o, e);
        end
    endtask

    // bp: 0 none, 1 every other cycle idle, 2 random idles. seq: data = word index.
    task automatic send_frame(input int n, input int last_idx, input int bp,
                              input bit seq, input int done_at);
        for (int i = 0; i < n; i++) begin
            if (bp == 1 || (bp == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                tick();
                chk("gap_start", start_out, 0);
            end
            in_valid     = 1'b1;
            in_data      = seq ? DW'(i) : DW'($urandom_range(0, 16'hFFFF));
            in_last      = (i == last_idx);
            core_done_in = (i == done_at);
            chk("beat_ready", in_ready, 1);
            tick();
            exp_words[i] = in_data;
            if (i < n - 1) chk("beat_start", start_out, 0);
        end
        in_valid     = 1'b0;
        in_last      = 1'b0;
        core_done_in = 1'b0;
    endtask

    task automatic finish_frame(input bit ok, input int wait_cycles);
        if (ok) begin
            chk("fire_start", start_out, 1);
            chk("fire_busy", busy, 1);
            chk("fire_ready", in_ready, 0);
            chk("fire_err", frame_err, exp_err);
            check_buses("fire");
            core_done_in = 1'b1;
            tick();
            core_done_in = 1'b0;
            chk("wait_start", start_out, 0);
            chk("wait_busy", busy, 1);
            chk("wait_cnt", frame_cnt, exp_cnt);
            for (int w = 0; w < wait_cycles; w++) begin
                tick();
                chk("wait_ready", in_ready, 0);
                chk("wait_start2", start_out, 0);
            end
            check_buses("wait");
            core_done_in = 1'b1;
            tick();
            core_done_in = 1'b0;
            exp_cnt++;
            chk("done_ready", in_ready, 1);
            chk("done_busy", busy, 0);
            chk("done_cnt", frame_cnt, exp_cnt);
            check_buses("done");
        end else begin
            exp_err = 1'b1;
            chk("bad_start", start_out, 0);
            chk("bad_busy", busy, 0);
            chk("bad_ready", in_ready, 1);
            chk("bad_err", frame_err, 1);
            check_buses("bad");
            tick();
            chk("bad_start2", start_out, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < FRAME; i++) exp_words[i] = '0;

        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_out, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        check_buses("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);

        // Sequential frame, back to back
        send_frame(FRAME, FRAME - 1, 0, 1'b1, -1);
        finish_frame(1'b1, 5);
        chk("dt_const", dt_flat_out, 32'h0001_0000);
        chk("h15_const", h_prev_flat_out[255:240], 16'h0021);

        // Same frame under backpressure
        send_frame(FRAME, FRAME - 1, 1, 1'b1, -1);
        finish_frame(1'b1, 3);

        // Early last then a good frame
        send_frame(11, 10, 0, 1'b0, -1);
        finish_frame(1'b0, 0);
        send_frame(FRAME, FRAME - 1, 0, 1'b0, -1);
        finish_frame(1'b1, 2);

        // core_done pulsed while loading x is ignored
        send_frame(FRAME, FRAME - 1, 0, 1'b0, 15);
        finish_frame(1'b1, 5);

        // Missing last
        send_frame(FRAME, -1, 0, 1'b0, -1);
        finish_frame(1'b0, 0);

        for (int f = 0; f < 4; f++) begin
            send_frame(FRAME, FRAME - 1, 2, 1'b0, -1);
            finish_frame(1'b1, $urandom_range(0, 6));
        end

        // Reset while waiting for the core
        send_frame(FRAME, FRAME - 1, 0, 1'b0, -1);
        chk("pre_rst_start", start_out, 1);
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_start", start_out, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < FRAME; i++) exp_words[i] = '0;
        exp_cnt = '0;
        exp_err = 1'b0;
        chk("wrst_ready", in_ready, 1);
        chk("wrst_busy", busy, 0);
        chk("wrst_cnt", frame_cnt, 0);
        chk("wrst_err", frame_err, 0);
        check_buses("wrst");
        tick();
        chk("wrst_start", start_out, 0);

        send_frame(FRAME, FRAME - 1, 2, 1'b0, -1);
        finish_frame(1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
